// File: rtl/uart_mii_inject.sv
// ============================================================================
// uart_mii_inject : UART-loaded frame buffer replayed as MII preamble+payload
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_mii_inject #(
   parameter int CLKS_PER_BIT = 434,
   parameter int NIBBLE_DIV   = 2,
   parameter int BUF_DEPTH    = 2048,
   parameter int TIMEOUT      = 5000000
) (
   input  logic       clk_50,
   input  logic       reset_n,
   input  logic       uart_rx,
   output logic [3:0] mii_out,
   output logic       mii_en,
   output logic       mii_stb,
   output logic       busy,
   output logic       err
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT + 1);
   localparam int DW = (NIBBLE_DIV > 1) ? $clog2(NIBBLE_DIV) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int NW = (AW + 1 > 5) ? AW + 1 : 5;

   localparam logic [BW-1:0] HALF_BIT = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] FULL_BIT = BW'(CLKS_PER_BIT - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(NIBBLE_DIV - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [16:0]   LEN_MAX  = 17'(BUF_DEPTH);
   localparam logic [NW-1:0] PRE_LAST = NW'(15);
   localparam logic [NW-1:0] IFG_LAST = NW'(23);

   typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;
   typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_PRE, S_PAY, S_IFG} state_t;

   // ---------------- UART receiver ----------------
   logic          rx_s1_q, rx_s2_q, rx_prev_q;
   ustate_t       u_state_q;
   logic [BW-1:0] u_cnt_q;
   logic [2:0]    u_bit_q;
   logic [7:0]    u_shift_q;
   logic          byte_valid_q, uart_err_q;

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_prev_q    <= 1'b1;
         u_state_q    <= U_IDLE;
         u_cnt_q      <= '0;
         u_bit_q      <= '0;
         u_shift_q    <= '0;
         byte_valid_q <= 1'b0;
         uart_err_q   <= 1'b0;
      end else begin
         rx_s1_q      <= uart_rx;
         rx_s2_q      <= rx_s1_q;
         rx_prev_q    <= rx_s2_q;
         byte_valid_q <= 1'b0;
         uart_err_q   <= 1'b0;
         case (u_state_q)
            U_IDLE: begin
               if (rx_prev_q && !rx_s2_q) begin
                  u_state_q <= U_START;
                  u_cnt_q   <= '0;
               end
            end
            U_START: begin
               // A line already back high at mid-start is a glitch, not a byte.
               if (u_cnt_q == HALF_BIT) begin
                  u_cnt_q   <= '0;
                  u_bit_q   <= '0;
                  u_state_q <= rx_s2_q ? U_IDLE : U_DATA;
               end else begin
                  u_cnt_q <= u_cnt_q + 1'b1;
               end
            end
            U_DATA: begin
               if (u_cnt_q == FULL_BIT) begin
                  u_cnt_q   <= '0;
                  u_shift_q <= {rx_s2_q, u_shift_q[7:1]};
                  u_bit_q   <= u_bit_q + 1'b1;
                  if (u_bit_q == 3'd7) u_state_q <= U_STOP;
               end else begin
                  u_cnt_q <= u_cnt_q + 1'b1;
               end
            end
            U_STOP: begin
               if (u_cnt_q == FULL_BIT) begin
                  u_cnt_q   <= '0;
                  u_state_q <= U_IDLE;
                  if (rx_s2_q) byte_valid_q <= 1'b1;
                  else         uart_err_q   <= 1'b1;
               end else begin
                  u_cnt_q <= u_cnt_q + 1'b1;
               end
            end
            default: u_state_q <= U_IDLE;
         endcase
      end
   end

   // ---------------- frame FSM and MII transmitter ----------------
   state_t        state_q;
   logic [15:0]   len_q;
   logic [AW:0]   wr_ptr_q;
   logic [AW-1:0] rd_idx_q;
   logic [TW-1:0] tmo_q;
   logic [NW-1:0] nib_cnt_q;
   logic [DW-1:0] div_q;
   logic [3:0]    mii_out_q, hi_nib_q;
   logic          mii_en_q, mii_stb_q, err_q;
   logic [7:0]    rd_data_q;
   logic [7:0]    mem [BUF_DEPTH];

   logic          tick;
   logic [15:0]   len_new;
   logic [AW:0]   wr_next;
   logic [16:0]   pay_last;
   logic          wr_en;

   assign tick     = (div_q == DIV_LAST);
   assign len_new  = {len_q[15:8], u_shift_q};
   assign wr_next  = wr_ptr_q + 1'b1;
   assign pay_last = {len_q, 1'b0} - 17'd1;
   assign wr_en    = (state_q == S_DATA) && byte_valid_q;

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_LEN_HI;
         len_q     <= '0;
         wr_ptr_q  <= '0;
         rd_idx_q  <= '0;
         tmo_q     <= '0;
         nib_cnt_q <= '0;
         div_q     <= '0;
         mii_out_q <= '0;
         hi_nib_q  <= '0;
         mii_en_q  <= 1'b0;
         mii_stb_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         div_q     <= tick ? '0 : div_q + 1'b1;
         mii_stb_q <= tick;
         // Every error source merges into the one registered pulse.
         err_q     <= uart_err_q;
         case (state_q)
            S_LEN_HI: begin
               if (byte_valid_q) begin
                  len_q[15:8] <= u_shift_q;
                  tmo_q       <= '0;
                  state_q     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (byte_valid_q) begin
                  tmo_q <= '0;
                  if (len_new == 16'd0 || {1'b0, len_new} > LEN_MAX) begin
                     err_q   <= 1'b1;
                     state_q <= S_LEN_HI;
                  end else begin
                     len_q[7:0] <= u_shift_q;
                     wr_ptr_q   <= '0;
                     state_q    <= S_DATA;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= S_LEN_HI;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_DATA: begin
               if (byte_valid_q) begin
                  tmo_q    <= '0;
                  wr_ptr_q <= wr_next;
                  if (16'(wr_next) == len_q) begin
                     nib_cnt_q <= '0;
                     rd_idx_q  <= '0;
                     state_q   <= S_PRE;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= S_LEN_HI;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_PRE: begin
               if (byte_valid_q) err_q <= 1'b1;
               if (tick) begin
                  mii_en_q  <= 1'b1;
                  mii_out_q <= (nib_cnt_q == PRE_LAST) ? 4'hD : 4'h5;
                  if (nib_cnt_q == PRE_LAST) begin
                     nib_cnt_q <= '0;
                     state_q   <= S_PAY;
                  end else begin
                     nib_cnt_q <= nib_cnt_q + 1'b1;
                  end
               end
            end
            S_PAY: begin
               if (byte_valid_q) err_q <= 1'b1;
               if (tick) begin
                  mii_en_q <= 1'b1;
                  // Holding the high nibble lets the RAM fetch the next byte
                  // during the high-nibble slot, so reads never stall output.
                  if (!nib_cnt_q[0]) begin
                     mii_out_q <= rd_data_q[3:0];
                     hi_nib_q  <= rd_data_q[7:4];
                     rd_idx_q  <= rd_idx_q + 1'b1;
                  end else begin
                     mii_out_q <= hi_nib_q;
                  end
                  if (17'(nib_cnt_q) == pay_last) begin
                     nib_cnt_q <= '0;
                     state_q   <= S_IFG;
                  end else begin
                     nib_cnt_q <= nib_cnt_q + 1'b1;
                  end
               end
            end
            S_IFG: begin
               if (byte_valid_q) err_q <= 1'b1;
               if (tick) begin
                  mii_en_q  <= 1'b0;
                  mii_out_q <= 4'h0;
                  if (nib_cnt_q == IFG_LAST) begin
                     nib_cnt_q <= '0;
                     state_q   <= S_LEN_HI;
                  end else begin
                     nib_cnt_q <= nib_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= S_LEN_HI;
         endcase
      end
   end

   always_ff @(posedge clk_50) begin
      if (wr_en) mem[wr_ptr_q[AW-1:0]] <= u_shift_q;
      rd_data_q <= mem[rd_idx_q];
   end

   assign mii_out = mii_out_q;
   assign mii_en  = mii_en_q;
   assign mii_stb = mii_stb_q;
   assign busy    = (state_q != S_LEN_HI);
   assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_mii_inject.sv
// ============================================================================
// tb_uart_mii_inject : table-driven and randomized frames against a nibble model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_mii_inject;

   localparam int CPB   = 16;
   localparam int NDIV  = 4;
   localparam int DEPTH = 64;
   localparam int TMO   = 2000;

   logic       clk_50  = 1'b0;
   logic       reset_n = 1'b0;
   logic       uart_rx = 1'b1;
   logic [3:0] mii_out;
   logic       mii_en, mii_stb, busy, err;

   uart_mii_inject #(
      .CLKS_PER_BIT(CPB),
      .NIBBLE_DIV  (NDIV),
      .BUF_DEPTH   (DEPTH),
      .TIMEOUT     (TMO)
   ) dut (
      .clk_50 (clk_50),
      .reset_n(reset_n),
      .uart_rx(uart_rx),
      .mii_out(mii_out),
      .mii_en (mii_en),
      .mii_stb(mii_stb),
      .busy   (busy),
      .err    (err)
   );

   always #5 clk_50 = ~clk_50;

   int tests = 0;
   int fails = 0;

   logic [3:0] cap_q[$];
   logic [3:0] exp_q[$];
   logic [7:0] pl_q[$];
   int         err_cnt   = 0;
   int         viol      = 0;
   int         last_ifg  = -1;
   int         idle_slots = 0;

   typedef struct {
      logic [15:0] len;
      bit          fixed;
      int          exp_err;
      int          exp_nibs;
   } vec_t;

   vec_t       vecs [8];
   logic [7:0] basic_pl [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

   // Output monitor: captures enabled nibbles, counts err pulses and IFG slots,
   // and flags strobe-period, change-off-strobe and double-width err faults.
   initial begin
      int         since_stb;
      bit         stb_seen;
      logic [3:0] prev_out;
      logic       prev_en, prev_err, prev_busy;
      since_stb = 0; stb_seen = 0; prev_out = 0;
      prev_en = 0; prev_err = 0; prev_busy = 0;
      forever begin
         @(negedge clk_50);
         if (!reset_n) begin
            since_stb = 0; stb_seen = 0; prev_out = 0;
            prev_en = 0; prev_err = 0; prev_busy = 0;
         end else begin
            since_stb++;
            if (mii_stb) begin
               if (stb_seen && since_stb != NDIV) viol++;
               stb_seen  = 1;
               since_stb = 0;
               if (mii_en) begin
                  cap_q.push_back(mii_out);
                  idle_slots = 0;
               end else begin
                  idle_slots++;
               end
            end
            if (!mii_stb && (mii_out != prev_out || mii_en != prev_en)) viol++;
            if (!mii_en && mii_out != 4'h0) viol++;
            if (err) begin
               err_cnt++;
               if (prev_err) viol++;
            end
            if (prev_busy && !busy) last_ifg = idle_slots;
            prev_out  = mii_out;
            prev_en   = mii_en;
            prev_err  = err;
            prev_busy = busy;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic check_frame(input string name);
      int bad;
      bad = -1;
      tests++;
      if (cap_q.size() == exp_q.size())
         foreach (exp_q[i]) if (bad < 0 && cap_q[i] != exp_q[i]) bad = i;
      if (cap_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL %s: %0d nibbles sent, %0d required", name, cap_q.size(), exp_q.size());
      end else if (bad >= 0) begin
         fails++;
         $display("FAIL %s: nibble %0d is %h, required %h", name, bad, cap_q[bad], exp_q[bad]);
      end
   endtask

   // Reference: 15 preamble nibbles, SFD, then each byte low nibble first.
   function automatic void model_frame(input logic [7:0] pl[$]);
      exp_q.delete();
      repeat (15) exp_q.push_back(4'h5);
      exp_q.push_back(4'hD);
      foreach (pl[i]) begin
         exp_q.push_back(pl[i][3:0]);
         exp_q.push_back(pl[i][7:4]);
      end
   endfunction

   function automatic bit len_ok(input int l);
      return (l != 0) && (l <= DEPTH);
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk_50);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk_50);
      end
      uart_rx = stop_ok;
      repeat (CPB) @(negedge clk_50);
      uart_rx = 1'b1;
      if (!stop_ok) repeat (CPB) @(negedge clk_50);
      repeat (2) @(negedge clk_50);
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      int n;
      n = 0;
      while (busy && n < max_cyc) begin
         @(negedge clk_50);
         n++;
      end
      if (busy) begin
         tests++;
         fails++;
         $display("FAIL %s: busy still high after %0d cycles", name, max_cyc);
      end
   endtask

   task automatic run_vec(input vec_t t);
      logic [7:0] b;
      int         e0;
      string      nm;
      nm = $sformatf("vec len=%0d", t.len);
      cap_q.delete();
      pl_q.delete();
      last_ifg = -1;
      e0 = err_cnt;
      send_byte(t.len[15:8], 1'b1);
      send_byte(t.len[7:0], 1'b1);
      if (len_ok(int'(t.len))) begin
         for (int i = 0; i < int'(t.len); i++) begin
            b = t.fixed ? basic_pl[i] : 8'($urandom);
            pl_q.push_back(b);
            send_byte(b, 1'b1);
         end
         wait_idle(nm, 5000);
         model_frame(pl_q);
         check_frame({nm, " data"});
         check({nm, " ifg slots"}, last_ifg, 24);
      end else begin
         repeat (20) @(negedge clk_50);
      end
      check({nm, " nibbles"}, cap_q.size(), t.exp_nibs);
      check({nm, " err"}, err_cnt - e0, t.exp_err);
      check({nm, " busy"}, busy, 0);
   endtask

   initial begin
      int e0;
      int n;
      logic [7:0] b;

      vecs[0] = '{16'h0004, 1'b1, 0, 24};
      vecs[1] = '{16'h0000, 1'b0, 1, 0};
      vecs[2] = '{16'h0041, 1'b0, 1, 0};
      vecs[3] = '{16'h0001, 1'b0, 0, 18};
      vecs[4] = '{16'h0007, 1'b0, 0, 30};
      vecs[5] = '{16'h0100, 1'b0, 1, 0};
      vecs[6] = '{16'h0003, 1'b0, 0, 22};
      vecs[7] = '{16'h0002, 1'b0, 0, 20};

      reset_n = 1'b0;
      repeat (5) @(negedge clk_50);
      check("reset outputs", {mii_out, mii_en, mii_stb, busy, err}, 0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk_50);
      check("idle busy", busy, 0);

      for (int v = 0; v < 8; v++) run_vec(vecs[v]);

      // Short low glitch must be rejected at the mid-start resample.
      e0 = err_cnt;
      uart_rx = 1'b0;
      repeat (5) @(negedge clk_50);
      uart_rx = 1'b1;
      repeat (300) @(negedge clk_50);
      check("glitch err", err_cnt - e0, 0);
      check("glitch busy", busy, 0);

      // Framing error mid-payload: byte dropped, frame completes from good bytes.
      cap_q.delete();
      e0 = err_cnt;
      send_byte(8'h00, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'hA1, 1'b1);
      send_byte(8'h55, 1'b0);
      check("framing err pulse", err_cnt - e0, 1);
      send_byte(8'hB2, 1'b1);
      send_byte(8'hC3, 1'b1);
      wait_idle("framing frame", 5000);
      pl_q = {8'hA1, 8'hB2, 8'hC3};
      model_frame(pl_q);
      check_frame("framing frame data");
      check("framing total err", err_cnt - e0, 1);

      // Timeout on a partial frame.
      cap_q.delete();
      e0 = err_cnt;
      send_byte(8'h00, 1'b1);
      send_byte(8'h05, 1'b1);
      send_byte(8'hAA, 1'b1);
      check("timeout busy before", busy, 1);
      repeat (TMO - 300) @(negedge clk_50);
      check("timeout not early", err_cnt - e0, 0);
      repeat (600) @(negedge clk_50);
      check("timeout err", err_cnt - e0, 1);
      check("timeout busy after", busy, 0);
      check("timeout no tx", cap_q.size(), 0);

      // Full-depth frame with an overrun byte sent while it is transmitting.
      cap_q.delete();
      pl_q.delete();
      last_ifg = -1;
      e0 = err_cnt;
      send_byte(8'h00, 1'b1);
      send_byte(8'(DEPTH), 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         pl_q.push_back(b);
         send_byte(b, 1'b1);
      end
      n = 0;
      while (!mii_en && n < 500) begin
         @(negedge clk_50);
         n++;
      end
      check("full tx started", mii_en, 1);
      send_byte(8'h33, 1'b1);
      check("overrun err", err_cnt - e0, 1);
      wait_idle("full frame", 5000);
      model_frame(pl_q);
      check_frame("full frame data");
      check("full payload nibbles", longint'(cap_q.size()) - 16, 2 * DEPTH);
      check("full ifg slots", last_ifg, 24);

      // Reset during payload, then a fresh frame.
      cap_q.delete();
      send_byte(8'h00, 1'b1);
      send_byte(8'h08, 1'b1);
      for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
      n = 0;
      while (cap_q.size() < 24 && n < 2000) begin
         @(negedge clk_50);
         n++;
      end
      check("reset test reached payload", cap_q.size() >= 24, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("reset async mii_en", mii_en, 0);
      check("reset async outputs", {mii_out, mii_en, mii_stb, busy, err}, 0);
      repeat (5) @(negedge clk_50);
      reset_n = 1'b1;
      repeat (50) @(negedge clk_50);
      check("reset no resume", busy, 0);
      cap_q.delete();
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h7E, 1'b1);
      wait_idle("post-reset frame", 5000);
      pl_q = {8'h7E};
      model_frame(pl_q);
      check_frame("post-reset frame data");

      check("protocol violations", viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
